// File: rtl/reg_write_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_decoder
//  Description : Register-file write-back decoder with a pending-write
//                scoreboard. Produces registered one-hot write enables,
//                tracks reserved destination registers, stalls WAW issues
//                and flags RAW hazards on two source ports.
//  Config      : `define REG_WRITE_DECODER_ZERO_REG_EN makes register N-1 a
//                hard-wired zero register (never written, never reserved).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [ADDR_W-1:0]     wr_addr,
  output logic [2**ADDR_W-1:0]  wr_en,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W:0]       pend_count
);

  localparam int N = 2**ADDR_W;

  // Registers that may ever be written or reserved.
`ifdef REG_WRITE_DECODER_ZERO_REG_EN
  localparam logic [N-1:0] c_reg_mask = {1'b0, {(N-1){1'b1}}};
`else
  localparam logic [N-1:0] c_reg_mask = {N{1'b1}};
`endif

  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]  r_wr_en;
  logic [N-1:0]  r_pending;
  logic [ADDR_W:0] r_pend_count;

  logic [N-1:0]  w_wr_dec;
  logic [N-1:0]  w_iss_dec;
  logic          w_iss_ready;
  logic          w_iss_accept;
  logic [N-1:0]  w_wr_en_next;
  logic [N-1:0]  w_pending_next;
  logic [ADDR_W:0] w_count_next;

  // Decode write-back and issue targets, resolve WAW stall, and build the
  // next scoreboard state (set of a newly issued reservation wins over a
  // same-cycle clear).
  always_comb begin
    w_wr_dec       = (c_one << wr_addr) & c_reg_mask;
    w_iss_dec      = (c_one << iss_addr) & c_reg_mask;
    w_iss_ready    = ~r_pending[iss_addr] | (wr_valid & (wr_addr == iss_addr));
    w_iss_accept   = iss_valid & w_iss_ready;
    w_wr_en_next   = wr_valid ? w_wr_dec : '0;
    w_pending_next = r_pending;
    if (wr_valid) begin
      w_pending_next = w_pending_next & ~w_wr_dec;
    end
    if (w_iss_accept) begin
      w_pending_next = w_pending_next | w_iss_dec;
    end
  end

  // Population count of the next scoreboard so pend_count tracks pending
  // on the same edge.
  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < N; i++) begin
      w_count_next = w_count_next + {{ADDR_W{1'b0}}, w_pending_next[i]};
    end
  end

  // State registers; reset discards reservations and in-flight enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en      <= '0;
      r_pending    <= '0;
      r_pend_count <= '0;
    end else begin
      r_wr_en      <= w_wr_en_next;
      r_pending    <= w_pending_next;
      r_pend_count <= w_count_next;
    end
  end

  assign wr_en      = r_wr_en;
  assign pending    = r_pending;
  assign pend_count = r_pend_count;
  assign iss_ready  = w_iss_ready;
  // No bypass: a same-cycle write does not hide the hazard.
  assign hazard_a   = r_pending[rd_addr_a];
  assign hazard_b   = r_pending[rd_addr_b];

endmodule
`default_nettype wire

// File: tb/tb_reg_write_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_decoder
//  Description : Directed self-checking bench for reg_write_decoder
//                (ADDR_W = 5). Honours REG_WRITE_DECODER_ZERO_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_decoder;

  localparam int ADDR_W = 5;
  localparam int N      = 32;

  logic              clk;
  logic              reset_n;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_en;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic [N-1:0]      pending;
  logic [ADDR_W:0]   pend_count;

  int checks   = 0;
  int failures = 0;

  reg_write_decoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_ready  (iss_ready),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
    .pending    (pending),
    .pend_count (pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] zero;
    zero = '0;
    reset_n = 1'b0; idle(); wr_addr = '0; iss_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    #3;
    checks++; if (wr_en !== zero) begin failures++; $display("FAIL reset_wr_en got=%h exp=%h", wr_en, zero); end
    checks++; if (pending !== zero) begin failures++; $display("FAIL reset_pending got=%h exp=%h", pending, zero); end
    checks++; if (pend_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", pend_count); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%b exp=1", iss_ready); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_sweep();
    logic [N-1:0] exp;
    for (int a = 0; a < N; a++) begin
      wr_valid = 1'b1; wr_addr = a[ADDR_W-1:0];
      tick();
      exp = 32'h1 << a;
`ifdef REG_WRITE_DECODER_ZERO_REG_EN
      if (a == N-1) exp = '0;
`endif
      checks++; if (wr_en !== exp) begin failures++; $display("FAIL sweep_wr_en addr=%0d got=%h exp=%h", a, wr_en, exp); end
      checks++; if ($countones(wr_en) > 1) begin failures++; $display("FAIL sweep_onehot addr=%0d got=%h exp=<=1 bit", a, wr_en); end
    end
    wr_valid = 1'b0;
    tick();
    checks++; if (wr_en !== 32'h0) begin failures++; $display("FAIL sweep_idle got=%h exp=0", wr_en); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL sweep_pending got=%h exp=0", pending); end
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL waw_first_ready got=%b exp=1", iss_ready); end
    tick();
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL waw_second_ready got=%b exp=0", iss_ready); end
    checks++; if (pending !== 32'h8) begin failures++; $display("FAIL waw_pending got=%h exp=00000008", pending); end
    checks++; if (pend_count !== 6'd1) begin failures++; $display("FAIL waw_count got=%0d exp=1", pend_count); end
    tick();
    checks++; if (pending !== 32'h8) begin failures++; $display("FAIL waw_stalled_pending got=%h exp=00000008", pending); end
    iss_valid = 1'b0; wr_valid = 1'b1; wr_addr = 5'd3;
    tick();
    idle();
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL waw_clear_pending got=%h exp=0", pending); end
    checks++; if (pend_count !== 6'd0) begin failures++; $display("FAIL waw_clear_count got=%0d exp=0", pend_count); end
    checks++; if (wr_en !== 32'h8) begin failures++; $display("FAIL waw_wr_en got=%h exp=00000008", wr_en); end
    tick();
  endtask

  task automatic test_same_addr();
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    wr_valid = 1'b1; wr_addr = 5'd7;
    #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b exp=1", iss_ready); end
    tick();
    idle();
    checks++; if (wr_en !== 32'h80) begin failures++; $display("FAIL same_wr_en got=%h exp=00000080", wr_en); end
    checks++; if (pending !== 32'h80) begin failures++; $display("FAIL same_pending got=%h exp=00000080", pending); end
    checks++; if (pend_count !== 6'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", pend_count); end
    wr_valid = 1'b1; wr_addr = 5'd7;
    tick();
    idle();
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL same_clear got=%h exp=0", pending); end
  endtask

  task automatic test_diff_addr();
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    wr_valid = 1'b1; wr_addr = 5'd9; iss_addr = 5'd10;
    tick();
    idle();
    checks++; if (pending !== 32'h400) begin failures++; $display("FAIL diff_pending got=%h exp=00000400", pending); end
    checks++; if (wr_en !== 32'h200) begin failures++; $display("FAIL diff_wr_en got=%h exp=00000200", wr_en); end
    checks++; if (pend_count !== 6'd1) begin failures++; $display("FAIL diff_count got=%0d exp=1", pend_count); end
    wr_valid = 1'b1; wr_addr = 5'd10;
    tick();
    idle();
  endtask

  task automatic test_hazard();
    iss_valid = 1'b1; iss_addr = 5'd5;
    tick();
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    #1;
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL haz_a_set got=%b exp=1", hazard_a); end
    checks++; if (hazard_b !== 1'b0) begin failures++; $display("FAIL haz_b_clear got=%b exp=0", hazard_b); end
    wr_valid = 1'b1; wr_addr = 5'd5;
    #1;
    checks++; if (hazard_a !== 1'b1) begin failures++; $display("FAIL haz_no_bypass got=%b exp=1", hazard_a); end
    tick();
    idle();
    checks++; if (hazard_a !== 1'b0) begin failures++; $display("FAIL haz_a_after_wr got=%b exp=0", hazard_a); end
  endtask

  task automatic test_full();
    logic [ADDR_W:0] exp_cnt;
    for (int a = 0; a < N; a++) begin
      iss_valid = 1'b1; iss_addr = a[ADDR_W-1:0];
      tick();
    end
    idle();
`ifdef REG_WRITE_DECODER_ZERO_REG_EN
    exp_cnt = 6'd31;
`else
    exp_cnt = 6'd32;
`endif
    checks++; if (pend_count !== exp_cnt) begin failures++; $display("FAIL full_count got=%0d exp=%0d", pend_count, exp_cnt); end
    iss_addr = 5'd0;
    #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", iss_ready); end
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd4; wr_valid = 1'b1; wr_addr = 5'd0; tick();
    idle(); iss_addr = 5'd1;
    checks++; if (pending !== 32'h16) begin failures++; $display("FAIL mid_pre_pending got=%h exp=00000016", pending); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL mid_pending got=%h exp=0", pending); end
    checks++; if (pend_count !== 6'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", pend_count); end
    checks++; if (wr_en !== 32'h0) begin failures++; $display("FAIL mid_wr_en got=%h exp=0", wr_en); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", iss_ready); end
    tick();
    reset_n = 1'b1;
    iss_valid = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    checks++; if (pending !== 32'h40) begin failures++; $display("FAIL post_reset_pending got=%h exp=00000040", pending); end
    checks++; if (pend_count !== 6'd1) begin failures++; $display("FAIL post_reset_count got=%0d exp=1", pend_count); end
    wr_valid = 1'b1; wr_addr = 5'd6;
    tick();
    idle();
  endtask

  task automatic test_reg31();
    logic exp_bit;
`ifdef REG_WRITE_DECODER_ZERO_REG_EN
    exp_bit = 1'b0;
`else
    exp_bit = 1'b1;
`endif
    iss_valid = 1'b1; iss_addr = 5'd31;
    tick();
    idle();
    rd_addr_a = 5'd31;
    #1;
    checks++; if (pending[31] !== exp_bit) begin failures++; $display("FAIL r31_pending got=%b exp=%b", pending[31], exp_bit); end
    checks++; if (hazard_a !== exp_bit) begin failures++; $display("FAIL r31_hazard got=%b exp=%b", hazard_a, exp_bit); end
    checks++; if (iss_ready !== ~exp_bit) begin failures++; $display("FAIL r31_ready got=%b exp=%b", iss_ready, ~exp_bit); end
    wr_valid = 1'b1; wr_addr = 5'd31;
    tick();
    idle();
    checks++; if (wr_en[31] !== exp_bit) begin failures++; $display("FAIL r31_wr_en got=%b exp=%b", wr_en[31], exp_bit); end
    checks++; if (pending[31] !== 1'b0) begin failures++; $display("FAIL r31_clear got=%b exp=0", pending[31]); end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_waw();
    test_same_addr();
    test_diff_addr();
    test_hazard();
    test_full();
    test_reset_mid();
    test_reg31();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
